// File: rtl/decode.sv
// ---------------------------------------------------------------------------
// decode -- RV32I decode stage with register file and ID/EX pipeline register.
//
// Decodes the instruction presented by fetch into control fields and a
// sign-extended immediate, reads the 32x32 register file, and registers the
// result into the ID/EX slot consumed by execute. Stall, flush, an invalid
// fetch (update_i low) or the all-zero fetch bubble each load a bubble.
//
// Ports:
//   clk_i, rstn_i              clock (rising edge), async active-low reset
//   pc_i, instr_i, update_i    instruction from fetch and its valid qualifier
//   stall_en, flush            hazard-unit controls, both force a bubble
//   wb_en_i/addr_i/data_i      register-file write port from writeback
//   rs1_addr_d_o, rs2_addr_d_o combinational source addresses for hazards
//   remaining *_o              registered ID/EX fields
// ---------------------------------------------------------------------------
module decode #(
    parameter bit WbBypass = 1'b1
) (
    input  logic        clk_i,
    input  logic        rstn_i,
    input  logic [31:0] pc_i,
    input  logic [31:0] instr_i,
    input  logic        update_i,
    input  logic        stall_en,
    input  logic        flush,
    input  logic        wb_en_i,
    input  logic [4:0]  wb_addr_i,
    input  logic [31:0] wb_data_i,
    output logic [4:0]  rs1_addr_d_o,
    output logic [4:0]  rs2_addr_d_o,
    output logic        valid_o,
    output logic [31:0] pc_o,
    output logic [31:0] rs1_data_o,
    output logic [31:0] rs2_data_o,
    output logic [31:0] imm_o,
    output logic [4:0]  rs1_addr_o,
    output logic [4:0]  rs2_addr_o,
    output logic [4:0]  rd_addr_o,
    output logic        rd_we_o,
    output logic [3:0]  alu_op_o,
    output logic        alu_src_a_o,
    output logic        alu_src_b_o,
    output logic [2:0]  funct3_o,
    output logic        mem_rd_o,
    output logic        mem_wr_o,
    output logic        branch_o,
    output logic        jump_o,
    output logic [1:0]  wb_sel_o,
    output logic        illegal_o
);

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,  ALU_SUB  = 4'd1, ALU_SLL = 4'd2, ALU_SLT = 4'd3,
        ALU_SLTU = 4'd4,  ALU_XOR  = 4'd5, ALU_SRL = 4'd6, ALU_SRA = 4'd7,
        ALU_OR   = 4'd8,  ALU_AND  = 4'd9, ALU_PASS_B = 4'd10
    } alu_op_e;

    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [31:0] rs1_data;
        logic [31:0] rs2_data;
        logic [31:0] imm;
        logic [4:0]  rs1_addr;
        logic [4:0]  rs2_addr;
        logic [4:0]  rd_addr;
        logic        rd_we;
        alu_op_e     alu_op;
        logic        alu_src_a;
        logic        alu_src_b;
        logic [2:0]  funct3;
        logic        mem_rd;
        logic        mem_wr;
        logic        branch;
        logic        jump;
        logic [1:0]  wb_sel;
        logic        illegal;
    } idex_t;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] F7_ALT     = 7'b0100000;

    // Instruction fields
    logic [6:0] opcode, funct7;
    logic [2:0] funct3;
    logic [4:0] rs1, rs2, rd;
    assign opcode = instr_i[6:0];
    assign rd     = instr_i[11:7];
    assign funct3 = instr_i[14:12];
    assign rs1    = instr_i[19:15];
    assign rs2    = instr_i[24:20];
    assign funct7 = instr_i[31:25];

    assign rs1_addr_d_o = rs1;
    assign rs2_addr_d_o = rs2;

    // Immediates, all sign-extended from bit 31
    logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
    assign imm_i = {{20{instr_i[31]}}, instr_i[31:20]};
    assign imm_s = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
    assign imm_b = {{19{instr_i[31]}}, instr_i[31], instr_i[7], instr_i[30:25], instr_i[11:8], 1'b0};
    assign imm_u = {instr_i[31:12], 12'h000};
    assign imm_j = {{11{instr_i[31]}}, instr_i[31], instr_i[19:12], instr_i[20], instr_i[30:21], 1'b0};

    // Register file: x0 slot exists but is never written and never read.
    logic [31:0] regs [32];

    // NOTE: the register file is made of flops that must come up cleared, so
    // it is reset explicitly here rather than inferred as an uninitialised RAM.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            for (int i = 0; i < 32; i++) regs[i] <= '0;
        end else if (wb_en_i && (wb_addr_i != 5'd0)) begin
            regs[wb_addr_i] <= wb_data_i;
        end
    end

    logic [31:0] rs1_rdata, rs2_rdata;
    assign rs1_rdata = (rs1 == 5'd0) ? 32'h0 :
                       (WbBypass && wb_en_i && (wb_addr_i == rs1)) ? wb_data_i : regs[rs1];
    assign rs2_rdata = (rs2 == 5'd0) ? 32'h0 :
                       (WbBypass && wb_en_i && (wb_addr_i == rs2)) ? wb_data_i : regs[rs2];

    // funct3 -> ALU op shared by OP and OP-IMM; alt selects SUB / SRA.
    function automatic alu_op_e alu_from_f3(input logic [2:0] f3, input logic alt);
        case (f3)
            3'b000:  return alt ? ALU_SUB : ALU_ADD;
            3'b001:  return ALU_SLL;
            3'b010:  return ALU_SLT;
            3'b011:  return ALU_SLTU;
            3'b100:  return ALU_XOR;
            3'b101:  return alt ? ALU_SRA : ALU_SRL;
            3'b110:  return ALU_OR;
            default: return ALU_AND;
        endcase
    endfunction

    logic  bubble, illegal;
    idex_t dec, q;

    assign bubble = flush || stall_en || !update_i || (instr_i == 32'h0);

    // NOTE: dec and illegal receive a full default before the case, so no
    // decode path can leave them unassigned and infer a latch.
    always_comb begin
        dec          = '0;
        illegal      = 1'b0;
        dec.valid    = 1'b1;
        dec.pc       = pc_i;
        dec.rs1_data = rs1_rdata;
        dec.rs2_data = rs2_rdata;
        dec.rs1_addr = rs1;
        dec.rs2_addr = rs2;
        dec.rd_addr  = rd;
        dec.funct3   = funct3;
        dec.alu_op   = ALU_ADD;
        case (opcode)
            OPC_OP: begin
                dec.rd_we  = 1'b1;
                dec.alu_op = alu_from_f3(funct3, funct7[5]);
                illegal    = !((funct7 == 7'd0) ||
                               ((funct7 == F7_ALT) && ((funct3 == 3'b000) || (funct3 == 3'b101))));
            end
            OPC_OP_IMM: begin
                dec.rd_we     = 1'b1;
                dec.alu_src_b = 1'b1;
                dec.imm       = imm_i;
                // Upper immediate bits are only an opcode extension for shifts.
                dec.alu_op    = alu_from_f3(funct3, (funct3 == 3'b101) && funct7[5]);
                illegal       = ((funct3 == 3'b001) && (funct7 != 7'd0)) ||
                                ((funct3 == 3'b101) && (funct7 != 7'd0) && (funct7 != F7_ALT));
            end
            OPC_LOAD: begin
                dec.rd_we     = 1'b1;
                dec.mem_rd    = 1'b1;
                dec.wb_sel    = 2'd1;
                dec.alu_src_b = 1'b1;
                dec.imm       = imm_i;
                illegal       = (funct3 == 3'b011) || (funct3 == 3'b110) || (funct3 == 3'b111);
            end
            OPC_STORE: begin
                dec.mem_wr    = 1'b1;
                dec.alu_src_b = 1'b1;
                dec.imm       = imm_s;
                illegal       = (funct3 > 3'b010);
            end
            OPC_BRANCH: begin
                dec.branch    = 1'b1;
                dec.alu_src_a = 1'b1;
                dec.alu_src_b = 1'b1;
                dec.imm       = imm_b;
                illegal       = (funct3 == 3'b010) || (funct3 == 3'b011);
            end
            OPC_JAL: begin
                dec.rd_we     = 1'b1;
                dec.jump      = 1'b1;
                dec.wb_sel    = 2'd2;
                dec.alu_src_a = 1'b1;
                dec.alu_src_b = 1'b1;
                dec.imm       = imm_j;
            end
            OPC_JALR: begin
                dec.rd_we     = 1'b1;
                dec.jump      = 1'b1;
                dec.wb_sel    = 2'd2;
                dec.alu_src_b = 1'b1;
                dec.imm       = imm_i;
                illegal       = (funct3 != 3'b000);
            end
            OPC_LUI: begin
                dec.rd_we     = 1'b1;
                dec.alu_op    = ALU_PASS_B;
                dec.alu_src_b = 1'b1;
                dec.imm       = imm_u;
            end
            OPC_AUIPC: begin
                dec.rd_we     = 1'b1;
                dec.alu_src_a = 1'b1;
                dec.alu_src_b = 1'b1;
                dec.imm       = imm_u;
            end
            default: illegal = 1'b1;
        endcase

        // An illegal instruction still occupies the slot but has no side effects.
        if (illegal) begin
            dec.rd_we   = 1'b0;
            dec.mem_rd  = 1'b0;
            dec.mem_wr  = 1'b0;
            dec.branch  = 1'b0;
            dec.jump    = 1'b0;
            dec.illegal = 1'b1;
        end

        if (bubble) dec = '0;
    end

    // NOTE: pipeline state uses non-blocking assignments so every flop samples
    // the pre-edge values regardless of block evaluation order.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) q <= '0;
        else         q <= dec;
    end

    assign valid_o     = q.valid;
    assign pc_o        = q.pc;
    assign rs1_data_o  = q.rs1_data;
    assign rs2_data_o  = q.rs2_data;
    assign imm_o       = q.imm;
    assign rs1_addr_o  = q.rs1_addr;
    assign rs2_addr_o  = q.rs2_addr;
    assign rd_addr_o   = q.rd_addr;
    assign rd_we_o     = q.rd_we;
    assign alu_op_o    = q.alu_op;
    assign alu_src_a_o = q.alu_src_a;
    assign alu_src_b_o = q.alu_src_b;
    assign funct3_o    = q.funct3;
    assign mem_rd_o    = q.mem_rd;
    assign mem_wr_o    = q.mem_wr;
    assign branch_o    = q.branch;
    assign jump_o      = q.jump;
    assign wb_sel_o    = q.wb_sel;
    assign illegal_o   = q.illegal;

endmodule

// File: doc/decode.md
# decode

Decode stage of the RV32I pipeline, directly downstream of `fetch`. It takes the registered `pc_fetch`/`instr_o` pair and decodes the instruction into control fields and a sign-extended immediate. It reads the 32×32 register file (write port driven by writeback) and registers everything into the ID/EX pipeline register consumed by execute. Stall and flush come from the hazard unit and turn the ID/EX slot into a bubble.

## Interface
- `WbBypass`, default 1: when 1, a same-cycle writeback to a read register is forwarded to the read data (write-first); when 0, the read returns the old value.
- `clk_i`  in  1  clock; all flops on rising edge.
- `rstn_i`  in  1  reset, asynchronous, active-low.
- `pc_i`  in  32  PC of `instr_i` (from fetch `pc_fetch`).
- `instr_i`  in  32  instruction (from fetch `instr_o`); 32'h0 is fetch's flush bubble.
- `update_i`  in  1  fetch has left reset; when 0, input is invalid.
- `stall_en`  in  1  hazard stall; fetch holds `instr_i`, decode emits a bubble.
- `flush`  in  1  hazard flush; decode emits a bubble.
- `wb_en_i`  in  1  register-file write enable.
- `wb_addr_i`  in  5  write address.
- `wb_data_i`  in  32  write data.
- `rs1_addr_d_o`, `rs2_addr_d_o`  out  5  combinational source addresses of `instr_i`, for the hazard unit.
- Registered ID/EX outputs:
  - `valid_o` 1
  - `pc_o` 32
  - `rs1_data_o` 32
  - `rs2_data_o` 32
  - `imm_o` 32
  - `rs1_addr_o` 5
  - `rs2_addr_o` 5
  - `rd_addr_o` 5
  - `rd_we_o` 1
  - `alu_op_o` 4
  - `alu_src_a_o` 1 (0=rs1, 1=pc)
  - `alu_src_b_o` 1 (0=rs2, 1=imm)
  - `funct3_o` 3 (branch condition / memory size)
  - `mem_rd_o` 1
  - `mem_wr_o` 1
  - `branch_o` 1
  - `jump_o` 1
  - `wb_sel_o` 2 (0=ALU, 1=mem, 2=pc+4)
  - `illegal_o` 1

## Operation
- **Register file:** x1–x31 are flops, asynchronously cleared on reset. x0 always reads 0, and writes to x0 are dropped. Writes occur on every clock edge where `wb_en_i`=1, regardless of stall or flush.
- **Read bypass:** when `WbBypass`=1, `wb_en_i`=1, `wb_addr_i`==rsN and rsN≠0, read data = `wb_data_i`.
- **Immediates (all sign-extended from bit 31):**
  - I: `instr[31:20]`
  - S: `{instr[31:25],instr[11:7]}`
  - B: `{instr[31],instr[7],instr[30:25],instr[11:8],0}`
  - U: `{instr[31:12],12'h0}`
  - J: `{instr[31],instr[19:12],instr[20],instr[30:21],0}`
- **`alu_op` encoding:** 0 ADD, 1 SUB, 2 SLL, 3 SLT, 4 SLTU, 5 XOR, 6 SRL, 7 SRA, 8 OR, 9 AND, 10 PASS_B.
- **OP (0110011):** src rs1/rs2; op from funct3 plus `funct7[5]` (SUB, SRA); `rd_we`=1.
- **OP-IMM (0010011):** src rs1/imm-I; `funct7[5]` is honoured only for SRAI.
- **LOAD (0000011):** ADD rs1+imm-I; `mem_rd`=1; `wb_sel`=1; `rd_we`=1.
- **STORE (0100011):** ADD rs1+imm-S; `mem_wr`=1; `rd_we`=0.
- **BRANCH (1100011):** ADD pc+imm-B (target); `branch_o`=1; `rd_we`=0.
- **JAL (1101111):** ADD pc+imm-J; `jump_o`=1; `wb_sel`=2.
- **JALR (1100111):** ADD rs1+imm-I; `jump_o`=1; `wb_sel`=2.
- **LUI (0110111):** PASS_B imm-U.
- **AUIPC (0010111):** ADD pc+imm-U.
- **Illegal:** any other opcode, or an invalid funct3/funct7 combination. Result: `illegal_o`=1, `valid_o`=1, and `rd_we`, `mem_rd`, `mem_wr`, `branch`, `jump` all 0.
- **Bubble:** `valid_o`=0 and all side-effect controls (`rd_we`, `mem_rd`, `mem_wr`, `branch`, `jump`, `illegal`) = 0. Data fields are don't-care but driven 0.
- **Bubble is loaded when:** `flush`=1, or `stall_en`=1, or `update_i`=0, or `instr_i`==32'h0. A zero instruction is never flagged illegal.
- **Priority:** reset > flush > stall > normal decode.

## Timing
- Latency is 1 cycle: the `instr_i` present before edge N appears on the ID/EX outputs after edge N.
- Reset (async, immediate on `rstn_i` falling):
  - all ID/EX outputs = 0 (`alu_op`=ADD, `valid_o`=0);
  - all registers = 0;
  - state is held until `rstn_i` deasserts.
- Reset mid-operation discards the in-flight ID/EX contents; there is no partial write.
- A stalled instruction is re-presented by fetch and decoded on the first non-stall cycle, so each instruction reaches EX exactly once.
- Write and decode in the same cycle: the read data follows the `WbBypass` rule. A write that lands on the same edge as the ID/EX capture is visible to later reads.
- `rs1_addr_d_o`/`rs2_addr_d_o` are valid in the same cycle as `instr_i`, with no register stage.

## Test plan
- **Reset:** pulse `rstn_i` low mid-stream, asynchronously between edges → all outputs 0 immediately. After release, decoding `add x3,x1,x2` → both read data 0.
- **ADDI:** `0x00500093` (addi x1,x0,5) → next cycle `valid`=1, `rd`=1, `imm`=5, `alu_op`=0, `src_b`=1, `rd_we`=1.
- **Bypass:** wb x2=0xDEADBEEF in the same cycle as `0x002101B3` (add x3,x2,x2) → both read data 0xDEADBEEF (with `WbBypass`=1). A write of 0x1234 to x0 → x0 reads 0.
- **Branch:** `0xFE000EE3` (beq x0,x0,-4) with `pc_i`=0x80000010 → `imm`=0xFFFFFFFC, `branch`=1, `src_a`=1, `pc_o`=0x80000010, `rd_we`=0.
- **U/J types:**
  - `0x123452B7` (lui x5) → `imm`=0x12345000, `alu_op`=10.
  - `0x008000EF` (jal x1,+8) → `imm`=8, `jump`=1, `wb_sel`=2, `rd`=1.
- **Bubbles and illegal:**
  - `stall_en`=1 with a valid instruction → `valid`=0, `rd_we`=0.
  - `flush`+`stall_en` together → bubble.
  - `instr_i`=0 → bubble with `illegal`=0.
  - `0xFFFFFFFF` → `illegal`=1, `valid`=1, `rd_we`=0.
